// File: rtl/fft_frame_serializer.sv
// Captures a natural-order frame of N complex samples in one cycle and streams it out one sample per beat
// in bit-reversed index order. Optional macro FFT_SERIALIZER_DOUBLE_BUF_EN adds a shadow frame buffer.
module fft_frame_serializer #(
  parameter int N    = 32,
  parameter int LOGN = 5,
  parameter int DW   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*DW-1:0]      in_r_flat,
  input  logic [N*DW-1:0]      in_i_flat,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 busy,
  output logic                 fsm_state
);

  // Handshake: a frame is captured on a rising edge with in_valid && in_ready, and a sample
  // is transferred on a rising edge with out_valid && out_ready. A valid sample and its
  // sof/eof flags hold stable until transferred; neither side depends on the other's valid.

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

  state_t          state;
  logic [N*DW-1:0] act_r, act_i;
  logic [LOGN-1:0] idx;
  logic [LOGN-1:0] idx_nxt;
  logic            capture, transfer, last_xfer;
  logic            load_en;
  logic [N*DW-1:0] load_r, load_i;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    for (int b = 0; b < LOGN; b++) r[b] = v[LOGN-1-b];
    return r;
  endfunction

  function automatic logic [DW-1:0] pick(input logic [N*DW-1:0] flat, input logic [LOGN-1:0] k);
    return flat[int'(k)*DW +: DW];
  endfunction

  assign capture   = in_valid && in_ready;
  assign transfer  = out_valid && out_ready;
  assign last_xfer = transfer && (idx == LAST_IDX);
  assign idx_nxt   = idx + 1'b1;
  assign fsm_state = (state == STREAM);

`ifdef FFT_SERIALIZER_DOUBLE_BUF_EN
  logic [N*DW-1:0] shd_r, shd_i;
  logic            shadow_full;
  logic            shadow_load;

  assign in_ready    = !shadow_full;
  // A capture on the last beat of a frame bypasses the shadow and is promoted directly.
  assign shadow_load = capture && (state == STREAM) && !last_xfer;

  always_comb begin
    load_en = 1'b0;
    load_r  = in_r_flat;
    load_i  = in_i_flat;
    if (state == IDLE) begin
      load_en = capture;
    end else if (last_xfer) begin
      if (shadow_full) begin
        load_en = 1'b1;
        load_r  = shd_r;
        load_i  = shd_i;
      end else begin
        load_en = capture;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shd_r       <= '0;
      shd_i       <= '0;
      shadow_full <= 1'b0;
    end else if (shadow_load) begin
      shd_r       <= in_r_flat;
      shd_i       <= in_i_flat;
      shadow_full <= 1'b1;
    end else if (last_xfer && shadow_full) begin
      shadow_full <= 1'b0;
    end
  end
`else
  assign in_ready = (state == IDLE);

  always_comb begin
    load_en = (state == IDLE) && capture;
    load_r  = in_r_flat;
    load_i  = in_i_flat;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      act_r     <= '0;
      act_i     <= '0;
      idx       <= '0;
      out_r     <= '0;
      out_i     <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      busy      <= 1'b0;
    end else if (load_en) begin
      // Bit-reversal of index 0 is 0, so the first beat is sample 0 of the new frame.
      state     <= STREAM;
      act_r     <= load_r;
      act_i     <= load_i;
      idx       <= '0;
      out_r     <= pick(load_r, '0);
      out_i     <= pick(load_i, '0);
      out_valid <= 1'b1;
      out_sof   <= 1'b1;
      out_eof   <= 1'b0;
      busy      <= 1'b1;
    end else if (last_xfer) begin
      state     <= IDLE;
      idx       <= '0;
      out_r     <= '0;
      out_i     <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      busy      <= 1'b0;
    end else if (transfer) begin
      idx       <= idx_nxt;
      out_r     <= pick(act_r, bitrev(idx_nxt));
      out_i     <= pick(act_i, bitrev(idx_nxt));
      out_sof   <= 1'b0;
      out_eof   <= (idx_nxt == LAST_IDX);
    end
  end

endmodule

// File: doc/fft_frame_serializer.md
Name: fft_frame_serializer

Overview:
- Input-side counterpart of the FFT output sorter: the sorter collects a serial bit-reversed stream into a natural-order parallel frame; this block does the reverse.
- Captures one natural-order frame of N complex samples in parallel and streams it serially, one sample per accepted beat, in bit-reversed index order.
- Sits between the frame source and the FFT pipeline input and feeds the radix stages.
- Uses a valid/ready handshake on both sides.

Parameters:
- N, 32, samples per frame; power of two, minimum 4.
- LOGN, 5, log2(N); index width.
- DW, 16, signed width of each real and imaginary component.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- in_r_flat  in  N*DW  real parts; sample k occupies bits [k*DW+DW-1 : k*DW].
- in_i_flat  in  N*DW  imaginary parts; same packing.
- in_valid  in  1  frame present on in_*_flat.
- in_ready  out  1  block can capture a frame this cycle.
- out_r  out  DW  signed real part of current sample.
- out_i  out  DW  signed imaginary part of current sample.
- out_valid  out  1  out_r/out_i valid.
- out_ready  in  1  downstream accepts the sample.
- out_sof  out  1  first sample of frame (index 0).
- out_eof  out  1  last sample of frame (index N-1).
- busy  out  1  a frame is being streamed.

Behaviour:
- Reset (rst low, asynchronous):
  - All buffer registers, beat counter idx and outputs are cleared.
  - After reset: state IDLE, out_valid=0, out_sof=0, out_eof=0, out_r=0, out_i=0, busy=0, in_ready=1.
- Capture and transfer rules:
  - A capture occurs on a rising edge with in_valid && in_ready; all N samples are latched into the active buffer in one cycle.
  - An output transfer occurs on a rising edge with out_valid && out_ready.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On capture: go to STREAM, idx=0.
  - Latency: the first sample is valid on the cycle after capture.
- State STREAM:
  - out_valid=1, busy=1.
  - out_r/out_i = buffer[bitrev_LOGN(idx)]. For N=32 the sample indices come out in the order 0,16,8,24,4,20,12,28,2,... ,15,31.
  - out_sof = (idx==0); out_eof = (idx==N-1).
  - On transfer: idx increments.
  - On transfer with idx==N-1: idx wraps to 0 and the state returns to IDLE.
- Backpressure:
  - While out_valid && !out_ready, out_r, out_i, out_sof, out_eof and idx hold stable.
  - No sample is ever skipped or repeated.
- in_valid outside IDLE (no macro): ignored; in_ready=0; the buffer is untouched.
- Gap between frames (no macro): minimum one cycle with out_valid=0 between the last beat of one frame and the first beat of the next.
- Reset mid-frame: the frame is abandoned and all state clears. The first post-reset capture starts at idx=0 with out_sof=1.
- Arithmetic: no scaling or rounding; samples pass through bit-exact, sign preserved.

Optional Feature:
- Macro: FFT_SERIALIZER_DOUBLE_BUF_EN.
- When defined:
  - A second (shadow) buffer of N samples is added.
  - in_ready = shadow empty, in either state.
  - A capture during STREAM goes to the shadow buffer.
  - On the idx==N-1 transfer with shadow full: the shadow is promoted to active, the state stays STREAM, idx=0, out_sof=1 on the next cycle, and the shadow is marked empty. Frames stream back-to-back with no bubble.
  - Capture and last transfer in the same cycle: the captured frame is promoted directly; the next cycle streams it with no bubble.
  - A capture in IDLE loads the active buffer directly, as without the macro.
- When undefined: single buffer and the behaviour above, including the one-cycle gap.

Test Plan:
- Reset, then capture frame re[k]=k, im[k]=-k; out_ready=1 -> 32 consecutive beats: out_r=0,16,8,24,4,... ,15,31 and out_i the negation of each. out_sof only on beat 0, out_eof only on beat 31, then out_valid=0 and in_ready=1.
- Same frame; drop out_ready for 3 cycles at beat 5 -> out_r holds 20 with out_valid=1 for 4 cycles; the sequence resumes 12,28,... with nothing lost.
- in_valid held high with a second frame (re[k]=100+k) during streaming, no macro -> in_ready=0 throughout. The first frame completes unchanged; the second is captured after the gap and streams 100,116,108,...
- Assert rst low at beat 10 -> outputs 0 and in_ready=1 immediately. A new capture streams from out_sof=1 with sample 0.
- With FFT_SERIALIZER_DOUBLE_BUF_EN: two frames presented back-to-back, out_ready=1 -> 64 consecutive valid beats with no gap. out_sof on beats 0 and 32, out_eof on beats 31 and 63; beat 32 carries out_r=100.
- Sign check: re[0]=-32768, im[0]=32767, other samples 0 -> beat 0 out_r=-32768, out_i=32767; all other beats are 0.
